// File: rtl/tx_frame_sched_pkg.sv
// Shared types and sizes for the transmitter frame scheduler.
package tx_sched_pkg;

  localparam int NREQ = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_GAP
  } sched_state_t;

endpackage

// File: rtl/tx_frame_sched_if.sv
// Requester-side byte bus: per-requester valid/data/last with a per-requester ready.
interface tx_frame_sched_if;
  import tx_sched_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0][7:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;

  modport master (output req_valid, req_data, req_last, input req_ready);
  modport slave  (input req_valid, req_data, req_last, output req_ready);

endinterface

// File: rtl/tx_frame_sched_arb.sv
// Two-way round-robin pick: the requester named by rr_ptr wins when both are valid.
module rr_arb2
  import tx_sched_pkg::*;
(
  input  logic [NREQ-1:0] req_valid,
  input  logic            rr_ptr,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (req_valid[rr_ptr]) begin
      grant[rr_ptr] = 1'b1;
    end else if (req_valid[~rr_ptr]) begin
      grant[~rr_ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/tx_frame_sched.sv
// Frame scheduler sharing one Manchester transmitter between two byte-stream requesters,
// one whole frame at a time, with an enforced inter-frame gap and underrun detection.
module tx_frame_sched
  import tx_sched_pkg::*;
#(
  parameter int GAP_TICKS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            baud_tick,
  tx_frame_sched_if.slave req,
  input  logic            tx_rdy,
  input  logic            tx_txen,
  output logic [7:0]      tx_data,
  output logic            tx_send,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            frame_done,
  output logic            underrun
);

  localparam int GW = $clog2(GAP_TICKS + 1);

  sched_state_t    r_state;
  logic [7:0]      r_stg;
  logic            r_stg_valid;
  logic            r_stg_last;
  logic [7:0]      r_cur;
  logic            r_rr_ptr;
  logic [GW-1:0]   r_gap_cnt;
  logic [NREQ-1:0] r_grant;
  logic            r_frame_done;
  logic            r_underrun;
  logic            r_uflow;

  logic            w_ready_en;
  logic            w_xfer;
  logic            w_send;
  logic            w_acc;
  logic            w_starve;
  logic            w_sel;
  logic [NREQ-1:0] w_arb_grant;

  rr_arb2 u_arb (
    .req_valid (req.req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_arb_grant)
  );

  // Staging is single-entry, so a requester is only offered a slot while it is empty.
  assign w_ready_en = ((r_state == S_LOAD) || (r_state == S_STREAM)) && !r_stg_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : gen_ready
      assign req.req_ready[gi] = r_grant[gi] & w_ready_en;
    end
  endgenerate

  assign w_sel  = r_grant[1];
  assign w_xfer = |(req.req_valid & req.req_ready);

  // First byte of a frame waits for the transmitter to go idle; later bytes ride the TR7 tick.
  always_comb begin
    w_send = 1'b0;
    if (r_stg_valid) begin
      if (r_state == S_LOAD) begin
        w_send = ~tx_txen;
      end else begin
        w_send = (r_state == S_STREAM);
      end
    end
  end

  assign w_acc    = w_send & tx_rdy & baud_tick;
  assign w_starve = (r_state == S_STREAM) & baud_tick & tx_rdy & ~w_send;

  assign tx_send    = w_send;
  assign tx_data    = r_cur;
  assign grant      = r_grant;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_stg        <= 8'h00;
      r_stg_valid  <= 1'b0;
      r_stg_last   <= 1'b0;
      r_cur        <= 8'h00;
      r_rr_ptr     <= 1'b0;
      r_gap_cnt    <= '0;
      r_grant      <= '0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      r_uflow      <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;

      // A transfer and an accept are mutually exclusive through stg_valid.
      if (w_xfer) begin
        r_stg       <= req.req_data[w_sel];
        r_stg_last  <= req.req_last[w_sel];
        r_stg_valid <= 1'b1;
      end
      if (w_acc) begin
        r_cur       <= r_stg;
        r_stg_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_uflow <= 1'b0;
          if (r_stg_valid) begin
            r_state <= S_LOAD;
          end else if (|req.req_valid) begin
            r_grant <= w_arb_grant;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_acc) begin
            r_state <= r_stg_last ? S_DRAIN : S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_acc && r_stg_last) begin
            r_state <= S_DRAIN;
          end else if (w_starve) begin
            r_underrun <= 1'b1;
            r_uflow    <= 1'b1;
            r_state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!tx_txen) begin
            r_gap_cnt    <= GW'(GAP_TICKS);
            r_frame_done <= ~r_uflow;
            r_state      <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= S_IDLE;
            // A byte caught on the starvation edge keeps the owner for a follow-on frame.
            if (!r_stg_valid) begin
              r_grant  <= '0;
              r_rr_ptr <= ~r_grant[1];
            end
          end else if (baud_tick) begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Bench for tx_frame_sched driving a behavioural Manchester transmitter (switch = 0 timing)
// off a shared baud enable; transmitted bytes are checked against a scoreboard.
module tb_tx_frame_sched;

  localparam int TB_GAP  = 4;
  localparam int IDLE_ST = 0;
  localparam int TR0     = 1;
  localparam int TR3     = 4;
  localparam int TR7     = 8;
  localparam int EOF2    = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] div   = 3'd0;
  logic       baud_tick;
  logic       tx_rdy, tx_txen, tx_send, busy, frame_done, underrun;
  logic [7:0] tx_data;
  logic [1:0] grant;
  int         xst = IDLE_ST;
  logic       abort = 1'b0;

  tx_frame_sched_if rif ();

  tx_frame_sched #(.GAP_TICKS(TB_GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_tick  (baud_tick),
    .req        (rif.slave),
    .tx_rdy     (tx_rdy),
    .tx_txen    (tx_txen),
    .tx_data    (tx_data),
    .tx_send    (tx_send),
    .grant      (grant),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 3'd1;
  assign baud_tick = (div == 3'd7);

  // Transmitter: IDLE, TR0..TR7, EOF1, EOF2; rdy in IDLE and TR7, txen whenever not idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xst <= IDLE_ST;
    end else if (baud_tick) begin
      case (xst)
        IDLE_ST: if (tx_send) xst <= TR0;
        TR7:     xst <= tx_send ? TR0 : TR7 + 1;
        EOF2:    xst <= IDLE_ST;
        default: xst <= xst + 1;
      endcase
    end
  end
  assign tx_rdy  = (xst == IDLE_ST) || (xst == TR7);
  assign tx_txen = (xst != IDLE_ST);

  // Scoreboard: written by the drivers, consumed by the monitor.
  logic [7:0] sb_data [256];
  logic [1:0] sb_own  [256];
  logic [7:0] sb_wr = 8'd0;
  logic [7:0] sb_rd = 8'd0;

  int n_chk_m = 0, n_pass_m = 0, n_chk_s = 0, n_pass_s = 0;
  int fd_cnt = 0, ud_cnt = 0, tf_cnt = 0, chg_cnt = 0;
  int gap_ticks = 0, rel_ticks = -1, gap_n = 0, g_n = 0;
  int gap_log [8];
  logic [1:0] g_log [8];
  logic       gap_on = 1'b0, prev_txen = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  logic [7:0] prev_data = 8'h00, cap = 8'h00;

  always @(negedge clk) begin
    prev_txen  <= tx_txen;
    prev_grant <= grant;
    prev_data  <= tx_data;
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (underrun) ud_cnt <= ud_cnt + 1;
    if (tx_data != prev_data) chg_cnt <= chg_cnt + 1;
    if (!rst_n) begin
      sb_rd  <= sb_wr;
      gap_on <= 1'b0;
      gap_n  <= 0;
      g_n    <= 0;
    end else begin
      if (prev_grant == 2'b00 && grant != 2'b00 && g_n < 8) begin
        g_log[g_n] <= grant;
        g_n        <= g_n + 1;
      end
      if (prev_txen && !tx_txen) begin
        tf_cnt    <= tf_cnt + 1;
        gap_on    <= 1'b1;
        gap_ticks <= 0;
        rel_ticks <= -1;
      end else if (gap_on) begin
        if (tx_send) begin
          gap_on <= 1'b0;
          if (gap_n < 8) begin
            gap_log[gap_n] <= gap_ticks;
            gap_n          <= gap_n + 1;
          end
        end else if (baud_tick) begin
          gap_ticks <= gap_ticks + 1;
        end
        if (grant == 2'b00 && rel_ticks < 0) rel_ticks <= gap_ticks;
      end
      if (baud_tick && xst == TR0) begin
        cap <= tx_data;
      end else if (baud_tick && xst > TR0 && xst < TR7) begin
        n_chk_m <= n_chk_m + 1;
        assert (tx_data === cap) n_pass_m <= n_pass_m + 1;
        else $error("FAIL data_stable: observed %h required %h in bit %0d", tx_data, cap, xst - TR0);
      end else if (baud_tick && xst == TR7) begin
        n_chk_m <= n_chk_m + 1;
        assert (sb_rd != sb_wr && {grant, tx_data} === {sb_own[sb_rd], sb_data[sb_rd]})
          n_pass_m <= n_pass_m + 1;
        else $error("FAIL tx_byte: observed grant %b data %h required grant %b data %h (pending %0d)",
                    grant, tx_data, sb_own[sb_rd], sb_data[sb_rd], sb_wr - sb_rd);
        if (sb_rd != sb_wr) sb_rd <= sb_rd + 8'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk_s++;
    assert (obs === exp) n_pass_s++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Offers n bytes (low byte first); 'fin' marks the final one as frame end.
  task automatic send_frame(input int r, input logic [31:0] bytes, input int n, input bit fin);
    logic got;
    for (int k = 0; k < n; k++) begin
      if (abort) return;
      rif.req_data[r]  = bytes[8*k +: 8];
      rif.req_last[r]  = fin && (k == n - 1);
      rif.req_valid[r] = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 2000 && !got && !abort; w++) begin
        @(negedge clk);
        if (rif.req_ready[r] && !abort) begin
          got            = 1'b1;
          sb_data[sb_wr] = bytes[8*k +: 8];
          sb_own[sb_wr]  = (r == 0) ? 2'b01 : 2'b10;
          sb_wr          = sb_wr + 8'd1;
        end
      end
      if (!got && !abort) check("handshake_timeout", 32'(got), 32'd1);
      @(posedge clk);
      #1;
      rif.req_valid[r] = 1'b0;
      rif.req_last[r]  = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int w = 0; w < 4000 && !ok; w++) begin
      @(negedge clk);
      ok = !busy && (xst == IDLE_ST);
    end
    if (!ok) check(tag, 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  int  f0, u0, t0, c0;
  logic ok3;

  initial begin
    rif.req_valid = '0;
    rif.req_data  = '0;
    rif.req_last  = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_req_ready", 32'(rif.req_ready), 32'd0);

    // Arbitration: both requesters pending from reset release.
    rst_n = 1'b1;
    f0 = fd_cnt;
    fork
      begin
        send_frame(0, 32'h0000_A2A1, 2, 1'b1);
        send_frame(0, 32'h0000_C2C1, 2, 1'b1);
      end
      send_frame(1, 32'h0000_B2B1, 2, 1'b1);
    join
    wait_idle("arb_idle_timeout");
    check("arb_grants_seen", 32'(g_n), 32'd3);
    check("arb_grant_1", 32'(g_log[0]), 32'b01);
    check("arb_grant_2", 32'(g_log[1]), 32'b10);
    check("arb_grant_3", 32'(g_log[2]), 32'b01);
    check("arb_gap_1", 32'(gap_log[0]), 32'(TB_GAP));
    check("arb_gap_2", 32'(gap_log[1]), 32'(TB_GAP));
    check("arb_frame_done", 32'(fd_cnt - f0), 32'd3);

    // Single-byte frame.
    f0 = fd_cnt;
    t0 = tf_cnt;
    send_frame(0, 32'h0000_00A5, 1, 1'b1);
    wait_idle("single_idle_timeout");
    check("single_frame_done", 32'(fd_cnt - f0), 32'd1);
    check("single_txen_falls", 32'(tf_cnt - t0), 32'd1);
    check("single_release_ticks", 32'(rel_ticks), 32'(TB_GAP));
    check("single_grant_idle", 32'(grant), 32'd0);

    // Three-byte frame: continuous txen, data changes only at byte boundaries.
    f0 = fd_cnt;
    t0 = tf_cnt;
    c0 = chg_cnt;
    send_frame(0, 32'h0033_2211, 3, 1'b1);
    wait_idle("three_idle_timeout");
    check("three_frame_done", 32'(fd_cnt - f0), 32'd1);
    check("three_txen_falls", 32'(tf_cnt - t0), 32'd1);
    check("three_data_changes", 32'(chg_cnt - c0), 32'd3);

    // Underrun: requester 1 supplies one byte then goes quiet.
    f0 = fd_cnt;
    u0 = ud_cnt;
    send_frame(1, 32'h0000_005A, 1, 1'b0);
    wait_idle("under_idle_timeout");
    check("under_pulse", 32'(ud_cnt - u0), 32'd1);
    check("under_no_done", 32'(fd_cnt - f0), 32'd0);
    send_frame(1, 32'h0000_00C3, 1, 1'b1);
    wait_idle("late_idle_timeout");
    check("late_frame_done", 32'(fd_cnt - f0), 32'd1);
    check("late_no_underrun", 32'(ud_cnt - u0), 32'd1);

    // Reset during TR3 of the first byte.
    fork
      send_frame(0, 32'h0077_6655, 3, 1'b1);
    join_none
    ok3 = 1'b0;
    for (int w = 0; w < 2000 && !ok3; w++) begin
      @(negedge clk);
      ok3 = (xst == TR3);
    end
    if (!ok3) check("tr3_timeout", 32'(ok3), 32'd1);
    #2;
    abort = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_data", 32'(tx_data), 32'h00);
    check("midrst_tx_send", 32'(tx_send), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req_ready", 32'(rif.req_ready), 32'd0);
    repeat (4) @(negedge clk);
    abort = 1'b0;
    rst_n = 1'b1;
    f0 = fd_cnt;
    send_frame(0, 32'h0000_003C, 1, 1'b1);
    wait_idle("post_rst_idle_timeout");
    check("post_rst_frame_done", 32'(fd_cnt - f0), 32'd1);
    check("scoreboard_drained", 32'(sb_rd), 32'(sb_wr));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass_s + n_pass_m, n_chk_s + n_chk_m);
    $finish;
  end

endmodule
